// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scancode decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE_SKIP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  localparam logic [2:0] PAUSE_TAIL = 3'd7;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ps2_event_t;

  // Keyboard status/response bytes that never represent a key.
  function automatic logic is_drop_code(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 make code to ASCII table (US layout).
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii
);

  logic [7:0]  w_letter;
  logic [15:0] w_sym;

  always_comb begin
    w_letter = 8'h00;
    case (i_code)
      8'h1C: w_letter = "a";  8'h32: w_letter = "b";  8'h21: w_letter = "c";
      8'h23: w_letter = "d";  8'h24: w_letter = "e";  8'h2B: w_letter = "f";
      8'h34: w_letter = "g";  8'h33: w_letter = "h";  8'h43: w_letter = "i";
      8'h3B: w_letter = "j";  8'h42: w_letter = "k";  8'h4B: w_letter = "l";
      8'h3A: w_letter = "m";  8'h31: w_letter = "n";  8'h44: w_letter = "o";
      8'h4D: w_letter = "p";  8'h15: w_letter = "q";  8'h2D: w_letter = "r";
      8'h1B: w_letter = "s";  8'h2C: w_letter = "t";  8'h3C: w_letter = "u";
      8'h2A: w_letter = "v";  8'h1D: w_letter = "w";  8'h22: w_letter = "x";
      8'h35: w_letter = "y";  8'h1A: w_letter = "z";
      default: w_letter = 8'h00;
    endcase
  end

  // Upper byte is the shifted character, lower byte the plain one.
  always_comb begin
    w_sym = 16'h0000;
    case (i_code)
      8'h45: w_sym = ")0";   8'h16: w_sym = "!1";   8'h1E: w_sym = "@2";
      8'h26: w_sym = "#3";   8'h25: w_sym = "$4";   8'h2E: w_sym = "%5";
      8'h36: w_sym = "^6";   8'h3D: w_sym = "&7";   8'h3E: w_sym = "*8";
      8'h46: w_sym = "(9";   8'h0E: w_sym = 16'h7E60; 8'h4E: w_sym = "_-";
      8'h55: w_sym = "+=";   8'h54: w_sym = "{[";   8'h5B: w_sym = "}]";
      8'h5D: w_sym = "|\\";  8'h4C: w_sym = ":;";   8'h52: w_sym = "\"'";
      8'h41: w_sym = "<,";   8'h49: w_sym = ">.";   8'h4A: w_sym = "?/";
      8'h29: w_sym = 16'h2020;
      8'h5A: w_sym = 16'h0D0D;
      8'h66: w_sym = 16'h0808;
      8'h76: w_sym = 16'h1B1B;
      8'h0D: w_sym = 16'h0909;
      default: w_sym = 16'h0000;
    endcase
  end

  always_comb begin
    o_ascii = 8'h00;
    if (w_letter != 8'h00)
      o_ascii = (i_shift ^ i_caps) ? (w_letter - ASCII_CASE_OFFSET) : w_letter;
    else
      o_ascii = i_shift ? w_sym[15:8] : w_sym[7:0];
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: prefix FSM, modifier tracking, ASCII mapping
// and a small event FIFO for the host.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_ps2_data,
  input  logic       i_ps2_valid,
  input  logic       i_key_rd,
  output logic       o_key_valid,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_break,
  output logic [7:0] o_key_ascii,
  output logic [3:0] o_mods,
  output logic       o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

  logic            r_valid_d;
  logic            w_strobe;
  ps2_state_e      r_state, w_state_nxt;
  logic [2:0]      r_pause_cnt, w_pause_cnt_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_emit, w_emit_ext, w_emit_brk;

  logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps, r_caps_held;
  logic w_shift;
  logic [7:0] w_lut_ascii;
  ps2_event_t w_event;

  ps2_event_t     r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
  logic           w_empty, w_full, w_push, w_pop;
  logic           r_overflow;
  ps2_event_t     w_head;

  assign w_strobe = i_ps2_valid & ~r_valid_d;
  assign w_shift  = r_lshift | r_rshift;

  ps2_ascii_lut u_lut (
    .i_code  (i_ps2_data),
    .i_shift (w_shift),
    .i_caps  (r_caps),
    .o_ascii (w_lut_ascii)
  );

  assign w_event = '{code:  i_ps2_data,
                     ext:   w_emit_ext,
                     brk:   w_emit_brk,
                     ascii: (w_emit_ext | w_emit_brk) ? 8'h00 : w_lut_ascii};

  always_comb begin
    w_state_nxt     = r_state;
    w_pause_cnt_nxt = r_pause_cnt;
    w_emit          = 1'b0;
    w_emit_ext      = 1'b0;
    w_emit_brk      = 1'b0;
    if (w_strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (i_ps2_data == PS2_EXT)        w_state_nxt = ST_EXT;
          else if (i_ps2_data == PS2_BRK)   w_state_nxt = ST_BRK;
          else if (i_ps2_data == PS2_PAUSE) begin
            w_state_nxt     = ST_PAUSE_SKIP;
            w_pause_cnt_nxt = PAUSE_TAIL;
          end else if (!is_drop_code(i_ps2_data)) w_emit = 1'b1;
        end
        ST_EXT: begin
          if (i_ps2_data == PS2_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (i_ps2_data == PS2_EXT) w_state_nxt = ST_EXT;
          else begin
            w_state_nxt = ST_IDLE;
            w_emit      = (i_ps2_data != KEY_LSHIFT);
            w_emit_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          w_emit      = 1'b1;
          w_emit_brk  = 1'b1;
        end
        ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          w_emit      = (i_ps2_data != KEY_LSHIFT);
          w_emit_ext  = 1'b1;
          w_emit_brk  = 1'b1;
        end
        ST_PAUSE_SKIP: begin
          w_pause_cnt_nxt = r_pause_cnt - 3'd1;
          if (r_pause_cnt <= 3'd1) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_to_cnt == TO_LAST) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_d   <= 1'b0;
      r_state     <= ST_IDLE;
      r_pause_cnt <= 3'd0;
      r_to_cnt    <= '0;
    end else begin
      r_valid_d   <= i_ps2_valid;
      r_state     <= w_state_nxt;
      r_pause_cnt <= w_pause_cnt_nxt;
      if (w_strobe || r_state == ST_IDLE || w_state_nxt == ST_IDLE)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TO_ONE;
    end
  end

  // Modifiers track every decoded event, even those the FIFO cannot accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_lalt      <= 1'b0;
      r_ralt      <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (w_emit) begin
      if (!w_emit_ext) begin
        case (i_ps2_data)
          KEY_LSHIFT: r_lshift <= ~w_emit_brk;
          KEY_RSHIFT: r_rshift <= ~w_emit_brk;
          KEY_CTRL:   r_lctrl  <= ~w_emit_brk;
          KEY_ALT:    r_lalt   <= ~w_emit_brk;
          KEY_CAPS: begin
            if (w_emit_brk) r_caps_held <= 1'b0;
            else begin
              if (!r_caps_held) r_caps <= ~r_caps;
              r_caps_held <= 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (i_ps2_data)
          KEY_CTRL: r_rctrl <= ~w_emit_brk;
          KEY_ALT:  r_ralt  <= ~w_emit_brk;
          default: ;
        endcase
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = i_key_rd & ~w_empty;
  assign w_push  = w_emit & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_event;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_emit && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_key_valid = ~w_empty;
  assign o_key_code  = w_empty ? 8'h00 : w_head.code;
  assign o_key_ext   = ~w_empty & w_head.ext;
  assign o_key_break = ~w_empty & w_head.brk;
  assign o_key_ascii = w_empty ? 8'h00 : w_head.ascii;
  assign o_mods      = {r_caps, r_lalt | r_ralt, r_lctrl | r_rctrl, w_shift};
  assign o_overflow  = r_overflow;

endmodule
